// File: rtl/imm_adder_arbiter_if.sv
// imm_adder_arbiter_if: request and result channels of the immediate-adder arbiter.
// slave  : the arbiter itself (accepts requests, presents results).
// master : the decode/control side driving requests and consuming results.
interface imm_adder_arbiter_if #(
  parameter int DATA_WIDTH = 32,
  parameter int TAG_WIDTH  = 4
);
  logic [1:0]            req_valid;
  logic [1:0]            req_ready;
  logic [1:0]            req0_op;
  logic [1:0]            req1_op;
  logic [DATA_WIDTH-1:0] req0_a;
  logic [DATA_WIDTH-1:0] req1_a;
  logic [DATA_WIDTH-1:0] req0_b;
  logic [DATA_WIDTH-1:0] req1_b;
  logic [TAG_WIDTH-1:0]  req0_tag;
  logic [TAG_WIDTH-1:0]  req1_tag;
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] out_result;
  logic                  out_src;
  logic [TAG_WIDTH-1:0]  out_tag;
  logic                  out_err;

  modport slave (
    input  req_valid, req0_op, req1_op, req0_a, req1_a, req0_b, req1_b, req0_tag, req1_tag,
    output req_ready,
    output out_valid, out_result, out_src, out_tag, out_err,
    input  out_ready
  );

  modport master (
    output req_valid, req0_op, req1_op, req0_a, req1_a, req0_b, req1_b, req0_tag, req1_tag,
    input  req_ready,
    input  out_valid, out_result, out_src, out_tag, out_err,
    output out_ready
  );
endinterface

// File: rtl/imm_adder_arbiter.sv
// imm_adder_arbiter: round-robin arbitration of one shared immediate adder between
// the upper-immediate former (requester 0) and the branch/jump target unit
// (requester 1), with a single registered, tagged result stage.
// Optional feature macro: IMM_ADDER_ARB_GRANT_COUNT_EN adds grant_count0/1 outputs
// counting accepted transfers per requester.
module imm_adder_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int TAG_WIDTH  = 4
) (
  input logic                clock,
  input logic                reset_n,
  imm_adder_arbiter_if.slave bus
`ifdef IMM_ADDER_ARB_GRANT_COUNT_EN
  ,
  output logic [31:0]        grant_count0,
  output logic [31:0]        grant_count1
`endif
);

  // Requester payloads gathered into arrays so the granted one can be indexed.
  logic [1:0]            op_arr  [2];
  logic [DATA_WIDTH-1:0] a_arr   [2];
  logic [DATA_WIDTH-1:0] b_arr   [2];
  logic [TAG_WIDTH-1:0]  tag_arr [2];

  assign op_arr[0]  = bus.req0_op;
  assign op_arr[1]  = bus.req1_op;
  assign a_arr[0]   = bus.req0_a;
  assign a_arr[1]   = bus.req1_a;
  assign b_arr[0]   = bus.req0_b;
  assign b_arr[1]   = bus.req1_b;
  assign tag_arr[0] = bus.req0_tag;
  assign tag_arr[1] = bus.req1_tag;

  logic                  out_valid_reg;
  logic [DATA_WIDTH-1:0] result_reg;
  logic                  src_reg;
  logic [TAG_WIDTH-1:0]  tag_reg;
  logic                  err_reg;
  logic                  last_grant_reg;

  logic                  can_accept;
  logic [1:0]            grant;
  logic                  transfer;
  logic                  sel;
  logic [DATA_WIDTH-1:0] sum;
  logic [DATA_WIDTH-1:0] sel_result;
  logic                  sel_err;

  // The stage can take a new result when empty or when the held one leaves this edge.
  assign can_accept = !out_valid_reg || bus.out_ready;

  // A requester wins when it is alone, or when it was not the last one served.
  // Held off while reset is asserted so req_ready reads 00 during reset.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_grant
      assign grant[gi] = reset_n && can_accept && bus.req_valid[gi] &&
                         (!bus.req_valid[1-gi] || (last_grant_reg != 1'(gi)));
    end
  endgenerate

  assign transfer      = |grant;
  assign sel           = grant[1];
  assign bus.req_ready = grant;

  // Single shared adder on the granted operands; carry-out is dropped.
  assign sum = a_arr[sel] + b_arr[sel];

  // Operation decode of the shared adder output.
  always_comb begin
    sel_result = sum;
    sel_err    = 1'b0;
    case (op_arr[sel])
      2'b00:   sel_result = b_arr[sel];
      2'b01:   sel_result = sum;
      2'b10:   sel_result = {sum[DATA_WIDTH-1:1], 1'b0};
      default: begin
        sel_result = '0;
        sel_err    = 1'b1;
      end
    endcase
  end

  // Result register and round-robin pointer; a new transfer takes precedence over draining.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      out_valid_reg  <= 1'b0;
      result_reg     <= '0;
      src_reg        <= 1'b0;
      tag_reg        <= '0;
      err_reg        <= 1'b0;
      last_grant_reg <= 1'b1;
    end else if (transfer) begin
      out_valid_reg  <= 1'b1;
      result_reg     <= sel_result;
      src_reg        <= sel;
      tag_reg        <= tag_arr[sel];
      err_reg        <= sel_err;
      last_grant_reg <= sel;
    end else if (out_valid_reg && bus.out_ready) begin
      out_valid_reg  <= 1'b0;
    end
  end

  assign bus.out_valid  = out_valid_reg;
  assign bus.out_result = result_reg;
  assign bus.out_src    = src_reg;
  assign bus.out_tag    = tag_reg;
  assign bus.out_err    = err_reg;

`ifdef IMM_ADDER_ARB_GRANT_COUNT_EN
  logic [31:0] count0_reg;
  logic [31:0] count1_reg;

  // Per-requester accepted-transfer counters, wrapping naturally at 2^32.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      count0_reg <= '0;
      count1_reg <= '0;
    end else begin
      if (grant[0]) count0_reg <= count0_reg + 32'd1;
      if (grant[1]) count1_reg <= count1_reg + 32'd1;
    end
  end

  assign grant_count0 = count0_reg;
  assign grant_count1 = count1_reg;
`endif

endmodule
